minitb_ahb_slave_mem: RTL

Synthesizable AHB-lite style memory slave. It sits directly downstream of the miniTB AHB master BFM and consumes its htrans/haddr/hwrite/hwdata traffic, returning hrdata and hready. Wait states are programmable per transfer, so benches can exercise the master's stall handling, pipelined writes and back-to-back reads against real RTL. It also provides transfer counters for self-checking.

---
 rtl/minitb_ahb_pkg.sv | 18 +
 rtl/minitb_sp_ram.sv | 37 +++
 rtl/minitb_ahb_slave_mem.sv | 116 +++++++++++
 3 files changed

// File: rtl/minitb_ahb_pkg.sv
// Shared AHB-lite definitions for the miniTB master BFM and memory slave:
// htrans encodings and the slave data-phase state.
package minitb_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_LAST = 2'b10
    } slave_state_e;

endpackage

// File: rtl/minitb_sp_ram.sv
// Word memory with one write port and one registered read port; a write
// and read of the same word on one edge returns the new data.
module minitb_sp_ram #(
    parameter int addrWidth = 8,
    parameter int dataWidth = 32
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 we,
    input  logic [addrWidth-1:0] waddr,
    input  logic [dataWidth-1:0] wdata,
    input  logic                 re,
    input  logic [addrWidth-1:0] raddr,
    output logic [dataWidth-1:0] rdata
);

    logic [dataWidth-1:0] mem [2**addrWidth];
    logic [dataWidth-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/minitb_ahb_slave_mem.sv
// AHB-lite memory slave with per-transfer programmable wait states and
// wrapping completed-transfer counters.
module minitb_ahb_slave_mem
    import minitb_ahb_pkg::*;
#(
    parameter int addrWidth = 8,
    parameter int dataWidth = 32,
    parameter int cntWidth  = 16
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic [1:0]           htrans,
    input  logic [addrWidth-1:0] haddr,
    input  logic                 hwrite,
    input  logic [dataWidth-1:0] hwdata,
    input  logic [WAIT_W-1:0]    wait_cycles,
    output logic                 hready,
    output logic [dataWidth-1:0] hrdata,
    output logic [cntWidth-1:0]  wr_count,
    output logic [cntWidth-1:0]  rd_count
);

    slave_state_e         state_reg, state_next;
    logic [WAIT_W-1:0]    cnt_reg, cnt_next;
    logic [addrWidth-1:0] addr_reg;
    logic                 wr_reg;
    logic [cntWidth-1:0]  wr_count_reg, rd_count_reg;

    logic                 accept;
    logic                 load_rd;
    logic [addrWidth-1:0] rd_addr;
    logic                 commit_wr, commit_rd;
    logic                 mem_we, mem_srst;

    assign accept    = (state_reg != S_WAIT) &&
                       ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    assign commit_wr = (state_reg == S_LAST) && wr_reg;
    assign commit_rd = (state_reg == S_LAST) && !wr_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load_rd    = 1'b0;
        rd_addr    = addr_reg;
        case (state_reg)
            S_WAIT: begin
                cnt_next = cnt_reg - WAIT_W'(1);
                if (cnt_reg <= WAIT_W'(1)) begin
                    state_next = S_LAST;
                    load_rd    = !wr_reg;
                end
            end
            default: begin
                if (accept) begin
                    cnt_next = wait_cycles;
                    rd_addr  = haddr;
                    if (wait_cycles == '0) begin
                        state_next = S_LAST;
                        load_rd    = !hwrite;
                    end else begin
                        state_next = S_WAIT;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            wr_reg       <= 1'b0;
            wr_count_reg <= '0;
            rd_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg <= haddr;
                wr_reg   <= hwrite;
            end
            if (commit_wr) begin
                wr_count_reg <= wr_count_reg + cntWidth'(1);
            end
            if (commit_rd) begin
                rd_count_reg <= rd_count_reg + cntWidth'(1);
            end
        end
    end

    // A write still in its data phase when reset arrives is dropped.
    assign mem_we   = commit_wr && hresetn;
    assign mem_srst = !hresetn;

    minitb_sp_ram #(
        .addrWidth(addrWidth),
        .dataWidth(dataWidth)
    ) u_ram (
        .clk  (hclk),
        .srst (mem_srst),
        .we   (mem_we),
        .waddr(addr_reg),
        .wdata(hwdata),
        .re   (load_rd),
        .raddr(rd_addr),
        .rdata(hrdata)
    );

    assign hready   = (state_reg != S_WAIT);
    assign wr_count = wr_count_reg;
    assign rd_count = rd_count_reg;

endmodule
